param_memory: RTL

PARAM_MEMORY -- requirements
Module: param_memory

---
 rtl/param_memory.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/param_memory.sv
// ---------------------------------------------------------------------------
// param_memory
//
// Single-port word memory behind a small request/ready handshake with a
// configurable number of wait states.
//
// A request is presented by raising en together with read or write, an
// address and (for writes) input_data.  Those qualifiers are captured on the
// request edge, so later changes to them have no effect on the transaction.
// After WAIT_CYCLES wait states the access is performed and ready rises.
// ready stays high until en is dropped.  A request that is not exactly one of
// read/write, or whose address is outside the populated depth, completes with
// error=1 and touches neither the RAM nor output_data.
//
// Parameters
//   DATA_W      data word width
//   ADDR_W      address width
//   DEPTH       number of words (1 .. 2**ADDR_W)
//   WAIT_CYCLES wait states before completion (0 .. 15)
//
// Ports
//   clk         clock, all state changes on the rising edge
//   reset       synchronous active-high reset
//   en          transaction request, held high until ready is seen
//   read        read qualifier
//   write       write qualifier
//   address     word address
//   input_data  write data
//   output_data registered read data, holds the last read value
//   ready       transaction complete
//   error       transaction completed without an access (illegal request)
// ---------------------------------------------------------------------------
module param_memory #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 128,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] input_data,
  output logic [DATA_W-1:0] output_data,
  output logic              ready,
  output logic              error
);

  // Index width into the storage array; at least one bit so a single-word
  // memory still has a legal select.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Depth widened by one bit so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  // Counter value at which the final wait state ends.  Unused when there
  // are no wait states, but kept well defined.
  localparam logic [3:0] LAST_CNT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  localparam bit NO_WAIT = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_reg;
  logic [3:0]        wait_cnt_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] data_reg;
  logic              rd_reg;
  logic              wr_reg;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  // Qualifiers used for the access.  With no wait states the access happens
  // on the request edge itself, before anything has been latched, so the live
  // inputs are used; otherwise the captured copies are.
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_data;
  logic              acc_rd;
  logic              acc_wr;
  logic [IDX_W-1:0]  acc_idx;
  logic              acc_legal;
  logic              acc_fire;

  always_comb begin
    acc_addr = addr_reg;
    acc_data = data_reg;
    acc_rd   = rd_reg;
    acc_wr   = wr_reg;
    if (state_reg == IDLE) begin
      acc_addr = address;
      acc_data = input_data;
      acc_rd   = read;
      acc_wr   = write;
    end
  end

  assign acc_idx   = acc_addr[IDX_W-1:0];
  assign acc_legal = (acc_rd ^ acc_wr) && ({1'b0, acc_addr} < DEPTH_EXT);

  // The access fires on the edge that enters DONE.  Reset masks it so a
  // write completing on a reset edge is never committed; dropping en in WAIT
  // aborts the request before it can fire.
  always_comb begin
    acc_fire = 1'b0;
    if (!reset && en) begin
      if (state_reg == IDLE && NO_WAIT)
        acc_fire = 1'b1;
      else if (state_reg == WAIT && wait_cnt_reg == LAST_CNT)
        acc_fire = 1'b1;
    end
  end

  // Storage: no reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (acc_fire && acc_legal && acc_wr)
      mem[acc_idx] <= acc_data;
  end

  // Control FSM with registered handshake outputs and read data register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= 4'd0;
      addr_reg     <= '0;
      data_reg     <= '0;
      rd_reg       <= 1'b0;
      wr_reg       <= 1'b0;
      output_data  <= '0;
      ready        <= 1'b0;
      error        <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          ready <= 1'b0;
          error <= 1'b0;
          if (en) begin
            addr_reg     <= address;
            data_reg     <= input_data;
            rd_reg       <= read;
            wr_reg       <= write;
            wait_cnt_reg <= 4'd0;
            if (NO_WAIT)
              state_reg <= DONE;
            else
              state_reg <= WAIT;
          end
        end

        WAIT: begin
          if (!en) begin
            // Request withdrawn: abandon it without touching memory.
            state_reg    <= IDLE;
            wait_cnt_reg <= 4'd0;
          end else if (wait_cnt_reg == LAST_CNT) begin
            state_reg    <= DONE;
            wait_cnt_reg <= 4'd0;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 4'd1;
          end
        end

        DONE: begin
          // Completion is held for as long as en stays high; no further
          // access is made until en has been low for an edge.
          if (!en) begin
            state_reg <= IDLE;
            ready     <= 1'b0;
            error     <= 1'b0;
          end
        end

        default: begin
          state_reg    <= IDLE;
          wait_cnt_reg <= 4'd0;
          ready        <= 1'b0;
          error        <= 1'b0;
        end
      endcase

      // Completion outputs and read data, on the edge entering DONE.
      if (acc_fire) begin
        ready <= 1'b1;
        error <= !acc_legal;
        if (acc_legal && acc_rd)
          output_data <= mem[acc_idx];
      end
    end
  end

endmodule
